// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-port RAM arbiter: RAM action codes,
// default memory size and the sequencer state encoding.
package ram_arbiter_pkg;

    localparam logic [1:0] RAM_NOP   = 2'b00;
    localparam logic [1:0] RAM_READ  = 2'b01;
    localparam logic [1:0] RAM_WRITE = 2'b10;

    localparam int MEM_SIZE_DEF = 1024;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // An out-of-bounds access must never reach the RAM as a real command.
    function automatic logic [1:0] ram_cmd(input logic [1:0] act, input logic oob);
        return oob ? RAM_NOP : act;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports plus the RAM-side command/data signals.
// The arbiter uses the slave view; requesters and the RAM sit on the master view.
interface ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              i_req0;
    logic [1:0]        i_act0;
    logic [ADDR_W-1:0] i_addr0;
    logic [DATA_W-1:0] i_wval0;
    logic              o_ack0;
    logic              o_err0;
    logic [DATA_W-1:0] o_rval0;

    logic              i_req1;
    logic [1:0]        i_act1;
    logic [ADDR_W-1:0] i_addr1;
    logic [DATA_W-1:0] i_wval1;
    logic              o_ack1;
    logic              o_err1;
    logic [DATA_W-1:0] o_rval1;

    logic [1:0]        o_ram_action;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_val;
    logic [DATA_W-1:0] i_ram_val;

    modport slave (
        input  i_req0, i_act0, i_addr0, i_wval0,
        input  i_req1, i_act1, i_addr1, i_wval1,
        input  i_ram_val,
        output o_ack0, o_err0, o_rval0,
        output o_ack1, o_err1, o_rval1,
        output o_ram_action, o_ram_addr, o_ram_val
    );

    modport master (
        output i_req0, i_act0, i_addr0, i_wval0,
        output i_req1, i_act1, i_addr1, i_wval1,
        output i_ram_val,
        input  o_ack0, o_err0, o_rval0,
        input  o_ack1, o_err1, o_rval1,
        input  o_ram_action, o_ram_addr, o_ram_val
    );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the port that was not
// granted last wins, otherwise the sole eligible port is chosen.
module rr_pick2 (
    input  logic [1:0] eligible_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |eligible_i;
        case (eligible_i)
            2'b11:   grant_o = ~last_i;
            2'b10:   grant_o = 1'b1;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and single-cycle sequencer in front of a
// big-endian 32-bit word RAM, with bounds checking and registered read data.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ram_arbiter_if.slave bus
);

    // One extra bit so addresses near the top of the address space cannot wrap.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(MEM_SIZE - 4);

    state_t            state_q;
    logic              last_q;
    logic              id_q;
    logic              oob_q;
    logic [1:0]        act_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rval_q [2];
    logic [1:0]        ram_action_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_val_q;

    logic [1:0]        eligible;
    logic              pick_id;
    logic              pick_valid;
    logic [1:0]        win_act;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wval;
    logic              win_oob;

    // A port whose ack is on the wire this cycle is still dropping its request.
    assign eligible = {bus.i_req1, bus.i_req0} & ~ack_q;

    rr_pick2 u_pick (
        .eligible_i (eligible),
        .last_i     (last_q),
        .grant_o    (pick_id),
        .valid_o    (pick_valid)
    );

    assign win_act  = pick_id ? bus.i_act1  : bus.i_act0;
    assign win_addr = pick_id ? bus.i_addr1 : bus.i_addr0;
    assign win_wval = pick_id ? bus.i_wval1 : bus.i_wval0;
    assign win_oob  = {1'b0, win_addr} > LAST_WORD;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            oob_q        <= 1'b0;
            act_q        <= RAM_NOP;
            ack_q        <= '0;
            err_q        <= '0;
            rval_q[0]    <= '0;
            rval_q[1]    <= '0;
            ram_action_q <= RAM_NOP;
            ram_addr_q   <= '0;
            ram_val_q    <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                IDLE: begin
                    ram_action_q <= RAM_NOP;
                    if (pick_valid) begin
                        id_q         <= pick_id;
                        last_q       <= pick_id;
                        act_q        <= win_act;
                        oob_q        <= win_oob;
                        ram_action_q <= ram_cmd(win_act, win_oob);
                        ram_addr_q   <= win_addr;
                        ram_val_q    <= win_wval;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_action_q <= RAM_NOP;
                    ack_q[id_q]  <= 1'b1;
                    err_q[id_q]  <= oob_q;
                    if (act_q == RAM_READ && !oob_q) begin
                        rval_q[id_q] <= bus.i_ram_val;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_ack0        = ack_q[0];
    assign bus.o_ack1        = ack_q[1];
    assign bus.o_err0        = err_q[0];
    assign bus.o_err1        = err_q[1];
    assign bus.o_rval0       = rval_q[0];
    assign bus.o_rval1       = rval_q[1];
    assign bus.o_ram_action  = ram_action_q;
    assign bus.o_ram_addr    = ram_addr_q;
    assign bus.o_ram_val     = ram_val_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomized bench for ram_arbiter: a byte RAM model answers the
// arbiter, and a transaction-level reference predicts grants, acks and data.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int MEM = 1024;

    typedef struct packed {
        logic [1:0]  act;
        logic [31:0] addr;
        logic [31:0] wval;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_arbiter #(.MEM_SIZE(MEM), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Byte-wide big-endian RAM with combinational read.
    logic [7:0] mem [MEM];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM; i++) mem[i] <= init_byte(i);
        end else if (bus.o_ram_action == RAM_WRITE && bus.o_ram_addr <= 32'(MEM - 4)) begin
            for (int i = 0; i < 4; i++) mem[int'(bus.o_ram_addr) + i] <= bus.o_ram_val[8*(3-i) +: 8];
        end
    end

    always_comb begin
        bus.i_ram_val = '0;
        if (bus.o_ram_addr <= 32'(MEM - 4)) begin
            for (int i = 0; i < 4; i++) bus.i_ram_val[8*(3-i) +: 8] = mem[int'(bus.o_ram_addr) + i];
        end
    end

    // Reference model: bytes written so far, otherwise the power-up pattern.
    bit [7:0]    ref_bytes [int];
    int          last_m;
    logic [31:0] exp_rval [2];

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 7 + 3) % 256);
    endfunction

    function automatic bit is_oob(input logic [31:0] a);
        return (64'(a) + 64'd4) > 64'(MEM);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            int b = int'(a) + i;
            r = {r[23:0], ref_bytes.exists(b) ? ref_bytes[b] : init_byte(b)};
        end
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) ref_bytes[int'(a) + i] = v[31 - 8*i -: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? bus.o_ack0 : bus.o_ack1;
    endfunction

    function automatic logic get_err(input int p);
        return (p == 0) ? bus.o_err0 : bus.o_err1;
    endfunction

    function automatic logic [31:0] get_rval(input int p);
        return (p == 0) ? bus.o_rval0 : bus.o_rval1;
    endfunction

    task automatic set_port(input int p, input txn_t t, input logic req);
        if (p == 0) begin
            bus.i_req0 = req; bus.i_act0 = t.act; bus.i_addr0 = t.addr; bus.i_wval0 = t.wval;
        end else begin
            bus.i_req1 = req; bus.i_act1 = t.act; bus.i_addr1 = t.addr; bus.i_wval1 = t.wval;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int   sel = int'($urandom_range(0, 7));
        t.act  = 2'($urandom_range(0, 2));
        t.wval = $urandom;
        if (sel < 6)       t.addr = 32'($urandom_range(0, MEM / 4 - 1) * 4);
        else if (sel == 6) t.addr = 32'(MEM - 4 + int'($urandom_range(0, 8)));
        else               t.addr = $urandom;
        return t;
    endfunction

    // Cycle N+1: the RAM sees the granted transaction.
    task automatic chk_access(input int p, input txn_t t);
        chk($sformatf("p%0d_ram_action", p), 32'(bus.o_ram_action), 32'(ram_cmd(t.act, is_oob(t.addr))));
        chk($sformatf("p%0d_ram_addr", p), bus.o_ram_addr, t.addr);
        if (t.act == RAM_WRITE) chk($sformatf("p%0d_ram_val", p), bus.o_ram_val, t.wval);
        chk("ack_in_access", 32'({bus.o_ack1, bus.o_ack0}), 32'd0);
    endtask

    // Cycle N+2: ack pulse; the model applies the transaction at this point.
    task automatic chk_ack(input int p, input txn_t t);
        bit oob = is_oob(t.addr);
        if (!oob && t.act == RAM_WRITE) ref_write(t.addr, t.wval);
        if (!oob && t.act == RAM_READ)  exp_rval[p] = ref_read(t.addr);
        chk($sformatf("p%0d_ack", p), 32'(get_ack(p)), 32'd1);
        chk($sformatf("p%0d_other_ack", p), 32'(get_ack(1 - p)), 32'd0);
        chk($sformatf("p%0d_err", p), 32'(get_err(p)), 32'(oob));
        chk($sformatf("p%0d_rval", p), get_rval(p), exp_rval[p]);
        chk($sformatf("p%0d_other_rval", p), get_rval(1 - p), exp_rval[1 - p]);
        chk("ram_idle_at_ack", 32'(bus.o_ram_action), 32'(RAM_NOP));
        $display("txn port=%0d act=%0d addr=%h wval=%h err=%0d rval=%h",
                 p, t.act, t.addr, t.wval, get_err(p), get_rval(p));
    endtask

    task automatic single(input int p, input txn_t t);
        set_port(p, t, 1'b1);
        step();
        chk_access(p, t);
        step();
        chk_ack(p, t);
        last_m = p;
        set_port(p, t, 1'b0);
        step();
        chk("ack_pulse_clears", 32'({bus.o_ack1, bus.o_ack0}), 32'd0);
    endtask

    // Both ports request continuously; each gets a new transaction at its ack.
    task automatic contend(input int n, input txn_t t0, input txn_t t1);
        txn_t t [2];
        int   w;
        t[0] = t0;
        t[1] = t1;
        set_port(0, t[0], 1'b1);
        set_port(1, t[1], 1'b1);
        w = 1 - last_m;
        for (int k = 0; k < n; k++) begin
            step();
            chk_access(w, t[w]);
            step();
            chk_ack(w, t[w]);
            last_m = w;
            t[w] = rand_txn();
            set_port(w, t[w], 1'b1);
            w = 1 - w;
        end
        set_port(0, t[0], 1'b0);
        set_port(1, t[1], 1'b0);
        step();
        chk("contend_drain", 32'(bus.o_ram_action), 32'(RAM_NOP));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_m = 1;
        exp_rval[0] = '0;
        exp_rval[1] = '0;
        step();
    endtask

    initial begin
        txn_t t;
        txn_t u;

        set_port(0, '0, 1'b0);
        set_port(1, '0, 1'b0);
        rst = 1'b1;
        mem_init = 1'b1;
        last_m = 1;
        exp_rval[0] = '0;
        exp_rval[1] = '0;
        step();
        step();
        chk("rst_ack", 32'({bus.o_ack1, bus.o_ack0}), 32'd0);
        chk("rst_err", 32'({bus.o_err1, bus.o_err0}), 32'd0);
        chk("rst_rval0", bus.o_rval0, 32'd0);
        chk("rst_rval1", bus.o_rval1, 32'd0);
        chk("rst_ram_action", 32'(bus.o_ram_action), 32'(RAM_NOP));
        chk("rst_ram_addr", bus.o_ram_addr, 32'd0);
        chk("rst_ram_val", bus.o_ram_val, 32'd0);
        mem_init = 1'b0;
        rst = 1'b0;
        step();

        // Write then read back, big-endian byte order.
        single(0, '{RAM_WRITE, 32'h10, 32'hDEADBEEF});
        single(0, '{RAM_READ, 32'h10, 32'h0});
        chk("byte_0x10", 32'(mem[16]), 32'hDE);
        chk("byte_0x13", 32'(mem[19]), 32'hEF);

        // NOP passes through without touching rval or memory.
        single(0, '{RAM_NOP, 32'h10, 32'h55555555});
        single(1, '{RAM_READ, 32'h10, 32'h0});

        // Bounds handling.
        single(1, '{RAM_WRITE, 32'(MEM - 3), 32'hCAFEF00D});
        single(1, '{RAM_READ, 32'(MEM - 4), 32'h0});
        single(1, '{RAM_WRITE, 32'hFFFFFFFE, 32'h11111111});
        single(1, '{RAM_READ, 32'hFFFFFFFC, 32'h0});
        single(1, '{RAM_WRITE, 32'(MEM - 4), 32'hA1B2C3D4});
        single(1, '{RAM_READ, 32'(MEM - 4), 32'h0});

        // Request held through the ack cycle: no regrant there, new grant after.
        t = '{RAM_READ, 32'h10, 32'h0};
        set_port(0, t, 1'b1);
        step();
        chk_access(0, t);
        step();
        chk_ack(0, t);
        step();
        chk("hold_no_regrant", 32'(bus.o_ram_action), 32'(RAM_NOP));
        chk("hold_no_ack", 32'(bus.o_ack0), 32'd0);
        step();
        chk_access(0, t);
        step();
        chk_ack(0, t);
        last_m = 0;
        set_port(0, t, 1'b0);
        step();

        // Reset during the ACCESS cycle of a write.
        single(0, '{RAM_WRITE, 32'h20, 32'hA5A5A5A5});
        t = '{RAM_WRITE, 32'h20, 32'h12345678};
        set_port(0, t, 1'b1);
        step();
        chk_access(0, t);
        rst = 1'b1;
        #1;
        chk("rst_mid_action", 32'(bus.o_ram_action), 32'(RAM_NOP));
        set_port(0, t, 1'b0);
        step();
        chk("rst_mid_no_ack", 32'({bus.o_ack1, bus.o_ack0}), 32'd0);
        rst = 1'b0;
        last_m = 1;
        exp_rval[0] = '0;
        exp_rval[1] = '0;
        step();
        chk("rst_mid_idle", 32'(bus.o_ram_action), 32'(RAM_NOP));
        chk("rst_mid_rval_cleared", bus.o_rval0, 32'd0);
        single(0, '{RAM_READ, 32'h20, 32'h0});

        // Contention from reset: port 0 first, then strict alternation.
        do_reset();
        t = '{RAM_READ, 32'h0, 32'h0};
        u = '{RAM_READ, 32'h4, 32'h0};
        contend(8, t, u);

        // Randomized single-port traffic.
        for (int k = 0; k < 40; k++) begin
            single(int'($urandom_range(0, 1)), rand_txn());
        end

        // Randomized contention starting from whichever port was granted last.
        contend(12, rand_txn(), rand_txn());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed, big-endian 32-bit word RAM.
- Port 0 is instruction fetch; port 1 is load/store.
- Accepts request/acknowledge transactions, grants the RAM round-robin, and drives its action, address and write value for exactly one cycle per access.
- Returns registered read data with an ack pulse, and rejects accesses whose word would exceed memory bounds.

Parameters:
- MEM_SIZE, 1024: RAM size in bytes; must equal the RAM's `MEM_SIZE.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; fixed at 32 because the RAM word is 4 bytes.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req0  in  1  port 0 request; held high until o_ack0.
- i_act0  in  2  port 0 action (`RAM_NOP/`RAM_READ/`RAM_WRITE); stable while i_req0 is high.
- i_addr0  in  32  port 0 byte address.
- i_wval0  in  32  port 0 write value.
- o_ack0  out  1  one-cycle completion pulse for port 0.
- o_err0  out  1  bounds error, valid with o_ack0.
- o_rval0  out  32  read data, valid with o_ack0.
- i_req1/i_act1/i_addr1/i_wval1/o_ack1/o_err1/o_rval1: same as port 0, for port 1.
- o_ram_action  out  2  to RAM i_action.
- o_ram_addr  out  32  to RAM i_addr.
- o_ram_val  out  32  to RAM i_val.
- i_ram_val  in  32  from RAM o_val (combinational read).

Behaviour:
- States: IDLE, ACCESS.
- Reset (async, immediate):
  - state=IDLE, last-grant pointer=1 so port 0 wins the first tie.
  - o_ack*=0, o_err*=0, o_rval*=0.
  - o_ram_action=`RAM_NOP, o_ram_addr=0, o_ram_val=0.
- IDLE, one or more eligible requests:
  - Pick the winner: if both are eligible, choose the port not equal to the last grant; otherwise the sole requester.
  - Latch the winner's id, action, addr and wval into registers; update last grant; go to ACCESS.
  - Eligible means i_reqN=1 and o_ackN=0 in that cycle. Requesters drop req on the ack cycle, so a req still high beside its own ack is never re-granted.
- ACCESS (exactly 1 cycle), RAM outputs come from the latched registers:
  - o_ram_action = latched action; forced to `RAM_NOP if the access is out of bounds.
  - o_ram_addr = latched addr; o_ram_val = latched wval.
  - Out of bounds means addr > MEM_SIZE-4. Compare unsigned and wide enough that addr near 2^32-1 cannot wrap.
- End of ACCESS edge:
  - A write commits inside the RAM.
  - o_rvalN <= i_ram_val for READ; o_rvalN holds its old value for WRITE, NOP or error.
  - o_ackN <= 1 for the granted port; o_errN <= bounds flag.
  - State returns to IDLE.
- Outputs in IDLE:
  - o_ram_action=`RAM_NOP; o_ram_addr/o_ram_val hold their last values.
  - The RAM is never written outside ACCESS.
- Timing and rate:
  - Latency: req seen in cycle N; RAM accessed in N+1; ack in N+2.
  - Throughput: one access per 2 cycles.
  - Back-to-back alternation under contention: ports granted 0,1,0,1...
- Ack/err are single-cycle pulses, cleared on the next edge. o_rvalN holds until the next read on that port.
- NOP request: passes through ACCESS with no RAM effect, acks with err=0.
- Reset mid-ACCESS: the pending write is not committed (RAM action drops to NOP asynchronously) and no ack is issued. Requesters re-issue after reset.
- Request dropped before ack: protocol violation. The latched transaction completes anyway, and the ack is still pulsed.

Decomposition:
- Shared defines header holds:
  - `RAM_NOP=2'b00, `RAM_READ=2'b01, `RAM_WRITE=2'b10 (shared with the RAM and the CPU).
  - `MEM_SIZE.
  - The state encodings IDLE=1'b0, ACCESS=1'b1.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin selector taking eligible[1:0] and last, and producing the grant and valid.

Test Plan:
- Reset, then port 0 writes 0xDEADBEEF to 0x10 → o_ram_action=`RAM_WRITE only in cycle N+1; o_ack0 in N+2 with err=0. Port 0 then reads 0x10 → o_rval0=0xDEADBEEF, and byte 0x10 holds 0xDE (big-endian).
- Both ports request in the same cycle (reads of 0x0 and 0x4) → port 0 acks at N+2, port 1 at N+4. Keep both requesting continuously → grants strictly alternate for 8 transactions.
- Port 1 write to addr MEM_SIZE-3 → o_err1=1 with o_ack1, RAM action stays `RAM_NOP, and memory is unchanged on readback. Addr 0xFFFFFFFE also gives err (no wrap). Addr MEM_SIZE-4 succeeds.
- Assert i_rst during the ACCESS cycle of a write of 0x12345678 to 0x20 → no ack, state IDLE, and a post-reset read of 0x20 returns the prior value.
- Requester holds req one cycle past ack (ack cycle included) → no duplicate grant in the ack cycle; a new transaction starts the following cycle.
- NOP request on port 0 → ack at N+2, err=0, o_rval0 unchanged, RAM untouched.
